dmem_write_arbiter: RTL
=======================

# dmem_write_arbiter

Arbitrates the single write port of the 8-entry x 16-bit data memory between two requesters: the pipeline's stage-3 memory write and the external loader/debug write path. Loader writes are captured in a one-entry holding register. The pipeline normally has priority, and a bounded wait counter keeps the loader from starving. All memory-side outputs are registered, so the memory sees at most one clean write per cycle.

## Interface
Parameters:
- DW, 16, data width
- AW, 3, address width (8 words)
- MAX_WAIT, 3, number of consecutive cycles a held loader write may lose before it is forced through (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  pipeline write request (stage-3 mem write enable)
- cpu_add  in  AW  pipeline write address
- cpu_data  in  DW  pipeline write data
- cpu_stall  out  1  pipeline must hold cpu_req/add/data and freeze stage 3 this cycle (combinational)
- tb_req  in  1  loader write request
- tb_add  in  AW  loader write address
- tb_data  in  DW  loader write data
- tb_busy  out  1  holding register occupied; loader request is ignored while high (registered)
- tb_drop  out  1  one-cycle pulse: held loader write discarded due to address collision (registered)
- mem_en  out  1  write enable to data memory (registered)
- mem_add  out  AW  write address to data memory (registered)
- mem_data  out  DW  write data to data memory (registered)
- grant_src  out  1  source of the current mem_* write: 0 = pipeline, 1 = loader (registered)

## Operation
- Holding register: hold_v, hold_add, hold_data.
  - The loader write is accepted when tb_req && !hold_v. Accepted data is latched at posedge.
  - It is never granted in the same cycle it is accepted.
- States:
  - EMPTY (hold_v=0).
  - HELD (hold_v=1, wait_cnt counts losses).
  - FORCE (HELD with wait_cnt == MAX_WAIT).
- EMPTY:
  - cpu_req → grant pipeline; cpu_stall=0.
  - A tb_req accepted this cycle → HELD, wait_cnt=0.
- HELD, cpu_req=0:
  - Grant loader, clear hold_v → EMPTY.
- HELD, cpu_req=1, cpu_add != hold_add:
  - Grant pipeline; wait_cnt+1.
  - When wait_cnt reaches MAX_WAIT → FORCE.
- HELD or FORCE, cpu_req=1, cpu_add == hold_add:
  - Grant pipeline, since the pipeline value is newer.
  - Discard the held entry; pulse tb_drop next cycle → EMPTY.
  - Collision takes precedence over FORCE.
- FORCE, cpu_req=1, addresses differ:
  - Grant loader; cpu_stall=1.
  - Clear hold_v, wait_cnt=0 → EMPTY.
  - The pipeline request is granted the following cycle.
- FORCE, cpu_req=0: grant loader → EMPTY.
- Grant effect at posedge:
  - mem_en=1, mem_add/mem_data from the winner, grant_src set.
  - With no grant, mem_en=0; mem_add, mem_data and grant_src hold their last values.
- tb_busy = hold_v.
  - The loader may issue a new request in the cycle after the grant or drop clears hold_v.
- cpu_stall is 1 only in FORCE with cpu_req=1 and a differing address; otherwise 0.
- wait_cnt is 4 bits and saturates at MAX_WAIT. It resets to 0 on every transition into EMPTY.

## Timing
- Reset (rst_n=0, asynchronous): hold_v=0, wait_cnt=0, state EMPTY. mem_en=0, mem_add=0, mem_data=0, grant_src=0, tb_drop=0, tb_busy=0. cpu_stall evaluates to 0.
- Reset asserted mid-operation discards any held loader write without a tb_drop pulse.
- Latency:
  - Pipeline request to mem_en: 1 cycle.
  - Loader request to mem_en: at least 2 cycles (accept, then grant); at most MAX_WAIT+2 cycles.
- Throughput: one write per cycle. Back-to-back grants are allowed.
- The pipeline samples cpu_stall before the posedge of the same cycle.
- The pipeline drives its inputs on negedge. cpu_stall depends only on registered state and the cpu_* inputs, with no combinational path from tb_* to cpu_stall.
- tb_drop is high for exactly one cycle per discard.

## Test plan
- Reset, then cpu_req=1, cpu_add=5, cpu_data=16'hA5A5 for one cycle → next cycle mem_en=1, mem_add=5, mem_data=16'hA5A5, grant_src=0. All outputs are 0 during reset.
- Idle pipeline, tb_req with tb_add=2, tb_data=16'h1234 → tb_busy=1 next cycle. The cycle after: mem_en=1, mem_add=2, grant_src=1, tb_busy=0.
- Held loader write to addr 1, pipeline writes addrs 3,4,5,6 continuously, MAX_WAIT=3:
  - Cycles 1-3 grant the pipeline.
  - Cycle 4: cpu_stall=1, loader granted (mem_add=1).
  - Cycle 5: pipeline write to 6 granted.
- Held loader write to addr 7 (16'hFFFF) and pipeline write to addr 7 (16'h0001) in the same cycle → mem_data=16'h0001, tb_drop pulses once, tb_busy=0. No further write to 7.
- tb_req held high while tb_busy=1 → the second request is ignored until tb_busy falls. The loader re-request is accepted exactly one cycle later.
- rst_n asserted asynchronously while HELD with wait_cnt=2 → outputs 0 immediately, no later write of the held data, tb_drop stays 0.

Source files
------------

// File: rtl/dmem_write_arbiter.sv
// Write-port arbiter for the 8x16 data memory: pipeline stage-3 writes versus
// loader/debug writes buffered in a one-entry holding register.
module dmem_write_arbiter #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 3,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_add,
  input  logic [DW-1:0] cpu_data,
  output logic          cpu_stall,
  input  logic          tb_req,
  input  logic [AW-1:0] tb_add,
  input  logic [DW-1:0] tb_data,
  output logic          tb_busy,
  output logic          tb_drop,
  output logic          mem_en,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_data,
  output logic          grant_src
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic [1:0] {StEmpty, StHeld, StForce} state_e;

  state_e        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] hold_add_q, hold_add_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          tb_drop_q, tb_drop_d;
  logic          mem_en_q, mem_en_d;
  logic [AW-1:0] mem_add_q, mem_add_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          grant_src_q;
  logic          grant_cpu, grant_tb, addr_hit;

  assign addr_hit = (cpu_add == hold_add_q);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    hold_add_d  = hold_add_q;
    hold_data_d = hold_data_q;
    grant_cpu   = 1'b0;
    grant_tb    = 1'b0;
    tb_drop_d   = 1'b0;
    cpu_stall   = 1'b0;
    unique case (state_q)
      StEmpty: begin
        grant_cpu = cpu_req;
        // A freshly accepted loader write waits at least one cycle for its grant.
        if (tb_req) begin
          state_d     = StHeld;
          wait_cnt_d  = 4'd0;
          hold_add_d  = tb_add;
          hold_data_d = tb_data;
        end
      end
      StHeld: begin
        if (!cpu_req) begin
          grant_tb   = 1'b1;
          state_d    = StEmpty;
          wait_cnt_d = 4'd0;
        end else if (addr_hit) begin
          grant_cpu  = 1'b1;
          tb_drop_d  = 1'b1;
          state_d    = StEmpty;
          wait_cnt_d = 4'd0;
        end else begin
          grant_cpu = 1'b1;
          if (wait_cnt_q < MaxWait) wait_cnt_d = wait_cnt_q + 4'd1;
          if (wait_cnt_q + 4'd1 >= MaxWait) state_d = StForce;
        end
      end
      StForce: begin
        // Same-address pipeline write is newer, so it still beats a forced loader write.
        if (cpu_req && addr_hit) begin
          grant_cpu = 1'b1;
          tb_drop_d = 1'b1;
        end else begin
          grant_tb  = 1'b1;
          cpu_stall = cpu_req;
        end
        state_d    = StEmpty;
        wait_cnt_d = 4'd0;
      end
      default: begin
        state_d    = StEmpty;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    mem_en_d   = grant_cpu | grant_tb;
    mem_add_d  = grant_tb ? hold_add_q  : cpu_add;
    mem_data_d = grant_tb ? hold_data_q : cpu_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      wait_cnt_q  <= 4'd0;
      hold_add_q  <= '0;
      hold_data_q <= '0;
      tb_drop_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_add_q   <= '0;
      mem_data_q  <= '0;
      grant_src_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hold_add_q  <= hold_add_d;
      hold_data_q <= hold_data_d;
      tb_drop_q   <= tb_drop_d;
      mem_en_q    <= mem_en_d;
      if (mem_en_d) begin
        mem_add_q   <= mem_add_d;
        mem_data_q  <= mem_data_d;
        grant_src_q <= grant_tb;
      end
    end
  end

  assign tb_busy   = (state_q != StEmpty);
  assign tb_drop   = tb_drop_q;
  assign mem_en    = mem_en_q;
  assign mem_add   = mem_add_q;
  assign mem_data  = mem_data_q;
  assign grant_src = grant_src_q;

endmodule
